// File: rtl/transmissor_16.sv
// transmissor_16: sends a 16-bit word as two asynchronous serial frames.
// The high byte goes first, then the low byte. Each frame has a start bit,
// N_BITS data bits sent LSB first, an optional even parity bit and one stop bit.
// Outputs are registered from next-state values, so they track the state register.
// Data bits come from an 8-bit byte, so N_BITS is expected to be at most 8.
module transmissor_16 #(
   parameter int BAUD_RATE = 115200,
   parameter int CLOCK_HZ  = 50_000_000,
   parameter int N_BITS    = 8,
   parameter int PARITY    = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        partida,
   input  logic [15:0] data_in,
   output logic        tx_serial,
   output logic        ocupado,
   output logic        pronto,
   output logic [2:0]  db_estado
);

   localparam int DIV   = CLOCK_HZ / BAUD_RATE;
   localparam int FRAME = N_BITS + 2 + ((PARITY != 0) ? 1 : 0);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W = $clog2(FRAME);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
   localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SEND_HIGH = 3'd2,
      SEND_LOW  = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t             state_r,    state_s;
   logic [CNT_W-1:0]   baud_cnt_r, baud_cnt_s;
   logic [BIT_W-1:0]   bit_idx_r,  bit_idx_s;
   logic [15:0]        word_r,     word_s;
   logic [7:0]         byte_s;
   logic               tx_r,       tx_s;
   logic               ocupado_r,  ocupado_s;
   logic               pronto_r,   pronto_s;

   // Even parity over the N_BITS data bits of a byte.
   function automatic logic parity_of(input logic [7:0] b);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] & (i < N_BITS));
      end
      return p;
   endfunction

   // Line level for frame position idx: start, data LSB first, parity, stop.
   function automatic logic frame_bit(input logic [7:0] b, input logic [BIT_W-1:0] idx);
      int   pos;
      logic v;
      pos = int'(idx);
      if (pos == 0) begin
         v = 1'b0;
      end else if (pos <= N_BITS) begin
         v = b[3'(pos - 1)];
      end else if ((PARITY != 0) && (pos == N_BITS + 1)) begin
         v = parity_of(b);
      end else begin
         v = 1'b1;
      end
      return v;
   endfunction

   // Next-state and next-output logic. Each output is computed from the next state.
   always_comb begin
      state_s    = state_r;
      baud_cnt_s = baud_cnt_r;
      bit_idx_s  = bit_idx_r;
      word_s     = word_r;
      case (state_r)
         IDLE: begin
            if (partida) begin
               state_s = LOAD;
               word_s  = data_in;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            state_s    = SEND_HIGH;
            baud_cnt_s = '0;
            bit_idx_s  = '0;
         end
         SEND_HIGH, SEND_LOW: begin
            if (baud_cnt_r == DIV_LAST) begin
               baud_cnt_s = '0;
               if (bit_idx_r == FRAME_LAST) begin
                  bit_idx_s = '0;
                  state_s   = (state_r == SEND_HIGH) ? SEND_LOW : DONE;
               end else begin
                  bit_idx_s = bit_idx_r + BIT_W'(1);
               end
            end else begin
               baud_cnt_s = baud_cnt_r + CNT_W'(1);
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      byte_s = (state_s == SEND_HIGH) ? word_s[15:8] : word_s[7:0];
      if ((state_s == SEND_HIGH) || (state_s == SEND_LOW)) begin
         tx_s = frame_bit(byte_s, bit_idx_s);
      end else begin
         tx_s = 1'b1;
      end
      ocupado_s = (state_s != IDLE);
      pronto_s  = (state_s == DONE);
   end

   // State, counters, latched word and registered outputs. Reset aborts any frame.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= IDLE;
         baud_cnt_r <= '0;
         bit_idx_r  <= '0;
         word_r     <= 16'h0000;
         tx_r       <= 1'b1;
         ocupado_r  <= 1'b0;
         pronto_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         baud_cnt_r <= baud_cnt_s;
         bit_idx_r  <= bit_idx_s;
         word_r     <= word_s;
         tx_r       <= tx_s;
         ocupado_r  <= ocupado_s;
         pronto_r   <= pronto_s;
      end
   end

   assign tx_serial = tx_r;
   assign ocupado   = ocupado_r;
   assign pronto    = pronto_r;
   assign db_estado = state_r;

endmodule

// File: tb/tb_transmissor_16.sv
// Directed testbench for transmissor_16: default instance plus a no-parity instance.
module tb_transmissor_16;

   localparam int DIV = 434;   // 50_000_000 / 115200

   // Expected line bits, index 0 = first bit on the line.
   // 0x0301: hi 0x03 -> 0,1,1,0,0,0,0,0,0,p0,1 ; lo 0x01 -> 0,1,0,0,0,0,0,0,0,p1,1
   localparam logic [21:0] EXP_0301 = 22'b11_0000000_1_0_1_0_000000_110;
   // 0x8001 no parity: hi 0x80 -> 0,0000000,1,1 ; lo 0x01 -> 0,1,0000000,1
   localparam logic [21:0] EXP_8001 = {2'b00, 20'b1_0000000_1_0_1_1_00000000};

   logic        clock;
   logic        reset, partida;
   logic [15:0] data_in;
   logic        tx, ocupado, pronto;
   logic [2:0]  db;
   logic        reset_np, partida_np;
   logic [15:0] data_np;
   logic        tx_np, ocupado_np, pronto_np;
   logic [2:0]  db_np;

   logic        use_np;
   logic        m_tx, m_ocupado, m_pronto;
   logic [2:0]  m_db;

   int checks;
   int errors;

   transmissor_16 dut (
      .clock(clock), .reset(reset), .partida(partida), .data_in(data_in),
      .tx_serial(tx), .ocupado(ocupado), .pronto(pronto), .db_estado(db)
   );

   transmissor_16 #(.PARITY(0)) dut_np (
      .clock(clock), .reset(reset_np), .partida(partida_np), .data_in(data_np),
      .tx_serial(tx_np), .ocupado(ocupado_np), .pronto(pronto_np), .db_estado(db_np)
   );

   assign m_tx      = use_np ? tx_np      : tx;
   assign m_ocupado = use_np ? ocupado_np : ocupado;
   assign m_pronto  = use_np ? pronto_np  : pronto;
   assign m_db      = use_np ? db_np      : db;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Raise partida with a word, check LOAD, return on the first start-bit cycle.
   task automatic start_word(input logic [15:0] d, input bit hold);
      if (use_np) begin partida_np = 1'b1; data_np = d; end
      else        begin partida    = 1'b1; data_in = d; end
      @(negedge clock);
      checks++;
      if (m_db !== 3'd1 || m_ocupado !== 1'b1 || m_tx !== 1'b1) begin
         errors++;
         $display("FAIL load_state: db=%0d ocupado=%b tx=%b, required db=1 ocupado=1 tx=1",
                  m_db, m_ocupado, m_tx);
      end
      if (!hold) begin
         if (use_np) partida_np = 1'b0; else partida = 1'b0;
      end
      @(negedge clock);
   endtask

   // Check every cycle of both frames, then DONE pulse and return to IDLE.
   task automatic run_word(input logic [21:0] expv, input int fl, input int pulse_at, input string tag);
      int c;
      bit bad;
      logic [2:0] exp_db;
      c = 0;
      for (int b = 0; b < 2 * fl; b++) begin
         bad    = 1'b0;
         exp_db = (b < fl) ? 3'd2 : 3'd3;
         for (int j = 0; j < DIV; j++) begin
            if (m_tx !== expv[b] || m_db !== exp_db || m_pronto !== 1'b0 || m_ocupado !== 1'b1)
               bad = 1'b1;
            if (c == pulse_at) begin
               partida = 1'b1; data_in = 16'hFFFF;
            end else if (c == pulse_at + 1) begin
               partida = 1'b0;
            end
            c++;
            @(negedge clock);
         end
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL %s_bit%0d: line/state wrong within bit, required tx=%b db=%0d for %0d cycles",
                     tag, b, expv[b], exp_db, DIV);
         end
      end
      checks++;
      if (m_pronto !== 1'b1 || m_db !== 3'd4 || m_tx !== 1'b1 || m_ocupado !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: pronto=%b db=%0d tx=%b ocupado=%b at cycle %0d, required 1 4 1 1",
                  tag, m_pronto, m_db, m_tx, m_ocupado, c);
      end
      @(negedge clock);
      checks++;
      if (m_pronto !== 1'b0 || m_db !== 3'd0 || m_tx !== 1'b1 || m_ocupado !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: pronto=%b db=%0d tx=%b ocupado=%b, required 0 0 1 0",
                  tag, m_pronto, m_db, m_tx, m_ocupado);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; reset_np = 1'b1; partida = 1'b1; partida_np = 1'b0;
      data_in = 16'h1234; data_np = 16'h0000;
      repeat (3) @(negedge clock);
      checks++;
      if (tx !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs: tx=%b ocupado=%b pronto=%b db=%0d, required 1 0 0 0",
                  tx, ocupado, pronto, db);
      end
      checks++;
      if (tx_np !== 1'b1 || db_np !== 3'd0) begin
         errors++;
         $display("FAIL reset_np: tx=%b db=%0d, required 1 0", tx_np, db_np);
      end
      partida = 1'b0; reset = 1'b0; reset_np = 1'b0;
      @(negedge clock);
      checks++;
      if (db !== 3'd0 || ocupado !== 1'b0) begin
         errors++;
         $display("FAIL reset_partida_ignored: db=%0d ocupado=%b, required 0 0", db, ocupado);
      end
   endtask

   task automatic test_frame_0301;
      start_word(16'h0301, 1'b0);
      data_in = 16'h0000;   // change after latching must not matter
      run_word(EXP_0301, 11, -10, "frame0301");
   endtask

   task automatic test_busy_drop;
      bit bad;
      start_word(16'h0301, 1'b0);
      run_word(EXP_0301, 11, 11 * DIV + 1000, "busy");
      bad = 1'b0;
      repeat (30) begin
         @(negedge clock);
         if (db !== 3'd0 || ocupado !== 1'b0 || tx !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL busy_no_second: a second transfer started, required staying IDLE");
      end
   endtask

   task automatic test_reset_abort;
      bit bad;
      start_word(16'h0301, 1'b0);
      repeat (2000) @(negedge clock);
      checks++;
      if (tx !== 1'b0 || db !== 3'd2) begin
         errors++;
         $display("FAIL abort_pre: tx=%b db=%0d, required 0 2", tx, db);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (tx !== 1'b1 || db !== 3'd0 || ocupado !== 1'b0 || pronto !== 1'b0) begin
         errors++;
         $display("FAIL abort_post: tx=%b db=%0d ocupado=%b pronto=%b, required 1 0 0 0",
                  tx, db, ocupado, pronto);
      end
      bad = 1'b0;
      repeat (100) begin
         @(negedge clock);
         if (pronto !== 1'b0 || db !== 3'd0 || tx !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL abort_quiet: activity after abort, required idle line and no pronto");
      end
   endtask

   // Bench-side receiver samples mid-bit; partida stays high to test re-acceptance.
   task automatic test_loopback_back_to_back;
      logic [7:0]  byt [2];
      logic        par [2];
      logic        frame_ok;
      logic        s;
      logic [15:0] data_out;
      logic        parity_ok;
      frame_ok = 1'b1;
      start_word(16'hA55A, 1'b1);
      for (int f = 0; f < 2; f++) begin
         byt[f] = 8'h00;
         par[f] = 1'b0;
         for (int k = 0; k < 11; k++) begin
            repeat (DIV / 2) @(negedge clock);
            s = tx;
            if (k == 0 && s !== 1'b0) frame_ok = 1'b0;
            else if (k >= 1 && k <= 8) byt[f][k-1] = s;
            else if (k == 9) par[f] = s;
            else if (k == 10 && s !== 1'b1) frame_ok = 1'b0;
            repeat (DIV - DIV / 2) @(negedge clock);
         end
      end
      data_out  = {byt[0], byt[1]};
      parity_ok = ((^byt[0]) == par[0]) && ((^byt[1]) == par[1]);
      checks++;
      if (data_out !== 16'hA55A) begin
         errors++;
         $display("FAIL loopback_data: data_out=%h, required a55a", data_out);
      end
      checks++;
      if (parity_ok !== 1'b1 || frame_ok !== 1'b1) begin
         errors++;
         $display("FAIL loopback_parity: parity_ok=%b frame_ok=%b, required 1 1", parity_ok, frame_ok);
      end
      checks++;
      if (pronto !== 1'b1 || db !== 3'd4) begin
         errors++;
         $display("FAIL loopback_done: pronto=%b db=%0d, required 1 4", pronto, db);
      end
      @(negedge clock);
      checks++;
      if (db !== 3'd0 || ocupado !== 1'b0) begin
         errors++;
         $display("FAIL held_idle: db=%0d ocupado=%b, required 0 0", db, ocupado);
      end
      @(negedge clock);
      checks++;
      if (db !== 3'd1 || ocupado !== 1'b1) begin
         errors++;
         $display("FAIL held_reaccept: db=%0d ocupado=%b, required 1 1", db, ocupado);
      end
      partida = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (db !== 3'd0) begin
         errors++;
         $display("FAIL held_reset: db=%0d, required 0", db);
      end
   endtask

   task automatic test_no_parity;
      use_np = 1'b1;
      start_word(16'h8001, 1'b0);
      run_word(EXP_8001, 10, -10, "noparity");
      use_np = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      use_np = 1'b0;
      test_reset();
      test_frame_0301();
      test_busy_drop();
      test_reset_abort();
      test_loopback_back_to_back();
      test_no_parity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
